tenyr_mem_ws: RTL and testbench

Parametrised successor to the two-port main memory, adding configurable wait states.
- Port 0 is read/write (operand traffic); port 1 is read-only (instruction fetch).
- Each port has its own req/ack handshake, an out-of-range error flag and independent latency sequencing.
- Sits between the core and storage and replaces the fixed zero-wait-state memory, so slower RAM models and future cache/bus fabrics can be plugged in.

---
 rtl/tenyr_mem_pkg.sv | 23 ++
 rtl/tenyr_mem_port_seq.sv | 88 ++++++++
 rtl/tenyr_mem_ws.sv | 104 ++++++++++
 tb/tb_tenyr_mem_ws.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tenyr_mem_pkg.sv
// Shared definitions for the wait-state main memory: sequencer state
// encoding, counter sizing and the address window check.
package tenyr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Width of the wait-state down-counter; it only ever holds LATENCY-2.
    function automatic int cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

    // True when base <= addr < base+size, no wrap-around.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input longint base,
                                           input longint size);
        return (addr >= 64'(base)) && (addr < 64'(base + size));
    endfunction

endpackage

// File: rtl/tenyr_mem_port_seq.sv
// Per-port request sequencer: latches a request, counts out the wait states
// and tells the storage when to commit and which latched values to use.
//
// state | meaning
// IDLE  | no transfer in flight, waiting for req
// BUSY  | request latched, counting down wait states
// DONE  | ack cycle; a new request may be accepted back-to-back
module tenyr_mem_port_seq
    import tenyr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 24,
    parameter int LATENCY    = 1,
    parameter bit WRITE_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  commit,
    output logic                  c_rw,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [DATA_WIDTH-1:0] c_wdata
);
    localparam int CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    seq_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic                  lat_rw;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  accept;

    assign accept = req && (state == IDLE || state == DONE);

    // With no wait states the access commits on the accepting edge, so the
    // live inputs are used; otherwise the latched copies are.
    assign commit  = !reset && ((LATENCY == 1) ? accept : (state == BUSY && cnt == '0));
    assign c_rw    = WRITE_EN && ((LATENCY == 1) ? rw : lat_rw);
    assign c_addr  = (LATENCY == 1) ? addr : lat_addr;
    assign c_wdata = (LATENCY == 1) ? wdata : lat_wdata;

    // Handshake FSM with registered ack and request latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        lat_rw    <= rw && WRITE_EN;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        if (LATENCY == 1) begin
                            state <= DONE;
                            ack   <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tenyr_mem_ws.sv
// Two-port main memory with configurable wait states. Port 0 reads and
// writes, port 1 only reads; each port sequences its own latency.
module tenyr_mem_ws
    import tenyr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 24,
    parameter int BASE       = 4096,
    parameter int SIZE       = 4096,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_rw,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_ack,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_ack,
    output logic                  p1_err
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                  p0_commit, p0_c_rw, p0_ok;
    logic [ADDR_WIDTH-1:0] p0_c_addr;
    logic [DATA_WIDTH-1:0] p0_c_wdata;
    logic [IDX_W-1:0]      p0_idx;
    logic                  p1_commit, p1_c_rw, p1_ok;
    logic [ADDR_WIDTH-1:0] p1_c_addr;
    logic [DATA_WIDTH-1:0] p1_c_wdata;
    logic [IDX_W-1:0]      p1_idx;
    logic                  unused_p1;

    logic [DATA_WIDTH-1:0] mem [SIZE];

    tenyr_mem_port_seq #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY(LATENCY), .WRITE_EN(1'b1)
    ) u_seq_p0 (
        .clk(clk), .reset(reset),
        .req(p0_req), .rw(p0_rw), .addr(p0_addr), .wdata(p0_wdata),
        .ack(p0_ack), .commit(p0_commit),
        .c_rw(p0_c_rw), .c_addr(p0_c_addr), .c_wdata(p0_c_wdata)
    );

    tenyr_mem_port_seq #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY(LATENCY), .WRITE_EN(1'b0)
    ) u_seq_p1 (
        .clk(clk), .reset(reset),
        .req(p1_req), .rw(1'b0), .addr(p1_addr), .wdata('0),
        .ack(p1_ack), .commit(p1_commit),
        .c_rw(p1_c_rw), .c_addr(p1_c_addr), .c_wdata(p1_c_wdata)
    );

    // Fetch port never writes; its write-side outputs are intentionally dropped.
    assign unused_p1 = p1_c_rw ^ (^p1_c_wdata);

    assign p0_ok  = addr_in_range(64'(p0_c_addr), BASE, SIZE);
    assign p1_ok  = addr_in_range(64'(p1_c_addr), BASE, SIZE);
    assign p0_idx = IDX_W'(p0_c_addr - ADDR_WIDTH'(BASE));
    assign p1_idx = IDX_W'(p1_c_addr - ADDR_WIDTH'(BASE));

    // Storage write; out-of-range writes are dropped so aliasing indices stay untouched.
    always_ff @(posedge clk) begin
        if (p0_commit && p0_c_rw && p0_ok) begin
            mem[p0_idx] <= p0_c_wdata;
        end
    end

    // Read data and error flags, held only for the ack cycle. Non-blocking
    // reads give port 1 the pre-write value on a same-edge collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rdata <= '0;
            p0_err   <= 1'b0;
            p1_rdata <= '0;
            p1_err   <= 1'b0;
        end else begin
            p0_rdata <= '0;
            p0_err   <= 1'b0;
            p1_rdata <= '0;
            p1_err   <= 1'b0;
            if (p0_commit) begin
                p0_err <= !p0_ok;
                if (p0_ok && !p0_c_rw) begin
                    p0_rdata <= mem[p0_idx];
                end
            end
            if (p1_commit) begin
                p1_err <= !p1_ok;
                if (p1_ok) begin
                    p1_rdata <= mem[p1_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_tenyr_mem_ws.sv
// Bench for tenyr_mem_ws: three instances with LATENCY 1, 4 and 3.
// Instance 0 runs a cycle-per-vector table; instances 1 and 2 run
// hand-written multi-cycle sequences (latency, latching, reset abort).
module tb_tenyr_mem_ws;

    localparam int LAT [3] = '{1, 4, 3};

    logic        clk;
    logic        rst      [3];
    logic        p0_req   [3];
    logic        p0_rw    [3];
    logic [23:0] p0_addr  [3];
    logic [31:0] p0_wdata [3];
    logic [31:0] p0_rdata [3];
    logic        p0_ack   [3];
    logic        p0_err   [3];
    logic        p1_req   [3];
    logic [23:0] p1_addr  [3];
    logic [31:0] p1_rdata [3];
    logic        p1_ack   [3];
    logic        p1_err   [3];

    int n_vec = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tenyr_mem_ws #(
            .DATA_WIDTH(32), .ADDR_WIDTH(24), .BASE(4096), .SIZE(4096),
            .LATENCY(LAT[g])
        ) u_dut (
            .clk(clk), .reset(rst[g]),
            .p0_req(p0_req[g]), .p0_rw(p0_rw[g]), .p0_addr(p0_addr[g]),
            .p0_wdata(p0_wdata[g]), .p0_rdata(p0_rdata[g]),
            .p0_ack(p0_ack[g]), .p0_err(p0_err[g]),
            .p1_req(p1_req[g]), .p1_addr(p1_addr[g]),
            .p1_rdata(p1_rdata[g]), .p1_ack(p1_ack[g]), .p1_err(p1_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic        w0;
        logic [23:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic [23:0] a1;
        logic        ea0;
        logic        ee0;
        logic [31:0] ed0;
        logic        ea1;
        logic        ee1;
        logic [31:0] ed1;
    } vec_t;

    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transfer on instance d; checks ack lands exactly LAT cycles after
    // acceptance and that inputs scrambled after acceptance are ignored.
    task automatic xfer(input int d, input bit port, input bit rw,
                        input logic [23:0] addr, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_rd,
                        input string name);
        logic a, e;
        logic [31:0] r;
        if (!port) begin
            p0_req[d] = 1'b1; p0_rw[d] = rw; p0_addr[d] = addr; p0_wdata[d] = wd;
        end else begin
            p1_req[d] = 1'b1; p1_addr[d] = addr;
        end
        for (int c = 0; c < LAT[d]; c++) begin
            step();
            if (c == 0) begin
                p0_req[d] = 1'b0; p1_req[d] = 1'b0;
                p0_addr[d] = 24'h000FFF; p1_addr[d] = 24'h000FFF;
                p0_wdata[d] = 32'hFFFF_FFFF; p0_rw[d] = ~rw;
            end
            a = port ? p1_ack[d] : p0_ack[d];
            e = port ? p1_err[d] : p0_err[d];
            r = port ? p1_rdata[d] : p0_rdata[d];
            chk($sformatf("%s ack c%0d", name, c), {31'd0, a}, {31'd0, c == LAT[d] - 1});
            if (c == LAT[d] - 1) begin
                chk({name, " err"}, {31'd0, e}, {31'd0, exp_err});
                if (!rw) chk({name, " rdata"}, r, exp_rd);
            end
        end
        step();
        a = port ? p1_ack[d] : p0_ack[d];
        chk({name, " ack pulse end"}, {31'd0, a}, 32'd0);
    endtask

    initial begin
        //            r0 w0 a0          d0            r1 a1          ea0 ee0 ed0           ea1 ee1 ed1
        tbl[0]  = '{1, 1, 24'h001000, 32'hDEADBEEF, 0, 24'h000000, 1, 0, 32'h0,        0, 0, 32'h0};
        tbl[1]  = '{1, 1, 24'h001001, 32'h0BADF00D, 0, 24'h000000, 1, 0, 32'h0,        0, 0, 32'h0};
        tbl[2]  = '{1, 0, 24'h001000, 32'h0,        0, 24'h000000, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0};
        tbl[3]  = '{1, 1, 24'h001FFF, 32'h12345678, 1, 24'h001001, 1, 0, 32'h0,        1, 0, 32'h0BADF00D};
        tbl[4]  = '{1, 1, 24'h002000, 32'h55555555, 1, 24'h000FFF, 1, 1, 32'h0,        1, 1, 32'h0};
        tbl[5]  = '{1, 0, 24'h001FFF, 32'h0,        1, 24'h001000, 1, 0, 32'h12345678, 1, 0, 32'hDEADBEEF};
        tbl[6]  = '{1, 1, 24'h001010, 32'h11111111, 0, 24'h000000, 1, 0, 32'h0,        0, 0, 32'h0};
        tbl[7]  = '{1, 1, 24'h001010, 32'h22222222, 1, 24'h001010, 1, 0, 32'h0,        1, 0, 32'h11111111};
        tbl[8]  = '{1, 0, 24'h000FFF, 32'h0,        1, 24'h001010, 1, 1, 32'h0,        1, 0, 32'h22222222};
        tbl[9]  = '{0, 0, 24'h001000, 32'h0,        0, 24'h001000, 0, 0, 32'h0,        0, 0, 32'h0};
        tbl[10] = '{1, 0, 24'h001001, 32'h0,        1, 24'h001FFF, 1, 0, 32'h0BADF00D, 1, 0, 32'h12345678};
        tbl[11] = '{1, 1, 24'h000FFF, 32'h99999999, 0, 24'h000000, 1, 1, 32'h0,        0, 0, 32'h0};
        tbl[12] = '{1, 0, 24'h001FFF, 32'h0,        0, 24'h000000, 1, 0, 32'h12345678, 0, 0, 32'h0};

        // Reset held 3 cycles with both requests asserted on every instance.
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            p0_req[d] = 1'b1; p0_rw[d] = 1'b1; p0_addr[d] = 24'h001000;
            p0_wdata[d] = 32'hFFFF_FFFF;
            p1_req[d] = 1'b1; p1_addr[d] = 24'h001000;
        end
        for (int c = 0; c < 3; c++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rst c%0d d%0d p0_ack", c, d), {31'd0, p0_ack[d]}, 32'd0);
                chk($sformatf("rst c%0d d%0d p0_err", c, d), {31'd0, p0_err[d]}, 32'd0);
                chk($sformatf("rst c%0d d%0d p0_rdata", c, d), p0_rdata[d], 32'd0);
                chk($sformatf("rst c%0d d%0d p1_ack", c, d), {31'd0, p1_ack[d]}, 32'd0);
                chk($sformatf("rst c%0d d%0d p1_err", c, d), {31'd0, p1_err[d]}, 32'd0);
                chk($sformatf("rst c%0d d%0d p1_rdata", c, d), p1_rdata[d], 32'd0);
            end
        end
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; p0_req[d] = 1'b0; p1_req[d] = 1'b0;
        end
        step();

        // LATENCY=1 table: each vector is accepted and acked on one edge.
        for (int i = 0; i < 13; i++) begin
            p0_req[0] = tbl[i].r0; p0_rw[0] = tbl[i].w0;
            p0_addr[0] = tbl[i].a0; p0_wdata[0] = tbl[i].d0;
            p1_req[0] = tbl[i].r1; p1_addr[0] = tbl[i].a1;
            step();
            chk($sformatf("v%0d p0_ack", i), {31'd0, p0_ack[0]}, {31'd0, tbl[i].ea0});
            chk($sformatf("v%0d p0_err", i), {31'd0, p0_err[0]}, {31'd0, tbl[i].ee0});
            if (!tbl[i].w0) chk($sformatf("v%0d p0_rdata", i), p0_rdata[0], tbl[i].ed0);
            chk($sformatf("v%0d p1_ack", i), {31'd0, p1_ack[0]}, {31'd0, tbl[i].ea1});
            chk($sformatf("v%0d p1_err", i), {31'd0, p1_err[0]}, {31'd0, tbl[i].ee1});
            chk($sformatf("v%0d p1_rdata", i), p1_rdata[0], tbl[i].ed1);
        end
        p0_req[0] = 1'b0; p1_req[0] = 1'b0;
        step();
        chk("l1 idle p0_ack", {31'd0, p0_ack[0]}, 32'd0);

        // LATENCY=4: exact ack timing and latched address on the fetch port.
        xfer(1, 1'b0, 1'b1, 24'h001001, 32'h0BADF00D, 1'b0, 32'h0, "l4 p0 wr 1001");
        xfer(1, 1'b1, 1'b0, 24'h001001, 32'h0,        1'b0, 32'h0BADF00D, "l4 p1 rd 1001");
        xfer(1, 1'b0, 1'b0, 24'h001001, 32'h0,        1'b0, 32'h0BADF00D, "l4 p0 rd 1001");
        xfer(1, 1'b1, 1'b0, 24'h002000, 32'h0,        1'b1, 32'h0, "l4 p1 rd 2000");

        // LATENCY=3: reset in the last BUSY cycle aborts a write.
        xfer(2, 1'b0, 1'b1, 24'h001020, 32'hAAAA0001, 1'b0, 32'h0, "l3 p0 wr 1020");
        p0_req[2] = 1'b1; p0_rw[2] = 1'b1; p0_addr[2] = 24'h001020; p0_wdata[2] = 32'hCAFEF00D;
        step();
        p0_req[2] = 1'b0;
        chk("l3 abort busy1 ack", {31'd0, p0_ack[2]}, 32'd0);
        step();
        chk("l3 abort busy0 ack", {31'd0, p0_ack[2]}, 32'd0);
        rst[2] = 1'b1;
        step();
        chk("l3 abort in-reset ack", {31'd0, p0_ack[2]}, 32'd0);
        rst[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("l3 abort after c%0d ack", c), {31'd0, p0_ack[2]}, 32'd0);
        end
        xfer(2, 1'b1, 1'b0, 24'h001020, 32'h0, 1'b0, 32'hAAAA0001, "l3 p1 rd 1020");
        xfer(2, 1'b0, 1'b0, 24'h001020, 32'h0, 1'b0, 32'hAAAA0001, "l3 p0 rd 1020");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
